// File: rtl/scm16_arb_pkg.sv
// Shared constants and state type for the SCM16 round-robin arbiter slice.
// NUM_REQ/IDX_W are fixed: the 4-bit index also feeds other SCM16 decoders.
package scm16_arb_pkg;

    localparam int NUM_REQ = 16;
    localparam int IDX_W   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/scm16_rr_arbiter_if.sv
// Request/grant bundle between requesters and the arbiter.
// master: drives req/en, sees grant; slave: the arbiter side.
interface scm16_rr_arbiter_if;
    import scm16_arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic               en;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_valid;
    logic               timeout_err;

    modport master (
        output req, en,
        input  grant, grant_idx, grant_valid, timeout_err
    );

    modport slave (
        input  req, en,
        output grant, grant_idx, grant_valid, timeout_err
    );

endinterface

// File: rtl/scm16_dec4_onehot.sv
// Combinational 4-to-16 one-hot decoder with active-high disable.
// Ports: sel_i (index), dis_i (force all zero), onehot_o (decoded lines).
module scm16_dec4_onehot
    import scm16_arb_pkg::*;
(
    input  logic [IDX_W-1:0]   sel_i,
    input  logic               dis_i,
    output logic [NUM_REQ-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (!dis_i) begin
            onehot_o = NUM_REQ'(1) << sel_i;
        end
    end

endmodule

// File: rtl/scm16_rr_arbiter.sv
// 16-way round-robin arbiter with grant hold, hold timeout and zero-gap handover.
// Ports: clk, rst (async active-low), bus (slave: req, en -> grant, grant_idx, grant_valid, timeout_err).
module scm16_rr_arbiter
    import scm16_arb_pkg::*;
#(
    parameter int HOLD_W   = 8,
    parameter int MAX_HOLD = 200
) (
    input  logic               clk,
    input  logic               rst,
    scm16_rr_arbiter_if.slave  bus
);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic               valid_q, valid_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               terr_q, terr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;

    logic [NUM_REQ-1:0] owner_oh;
    logic [NUM_REQ-1:0] cand;
    logic [IDX_W:0]     pick;
    logic               release_c;
    logic               timeout_c;

    // Scan last+1, last+2, ... wrapping; the 16th probe is last itself.
    function automatic logic [IDX_W:0] rr_pick(
        input logic [NUM_REQ-1:0] r,
        input logic [IDX_W-1:0]   last
    );
        logic [IDX_W-1:0] j;
        logic [IDX_W-1:0] w;
        logic             found;
        found = 1'b0;
        w     = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            j = last + IDX_W'(i);
            if (!found && r[j]) begin
                found = 1'b1;
                w     = j;
            end
        end
        return {found, w};
    endfunction

    assign owner_oh  = NUM_REQ'(1) << idx_q;
    assign release_c = (state_q == BUSY) && !bus.req[idx_q];
    assign timeout_c = (state_q == BUSY) && !release_c &&
                       (hold_q == HOLD_W'(MAX_HOLD));

    // The outgoing owner never takes part in its own handover.
    assign cand = (state_q == BUSY) ? (bus.req & ~owner_oh) : bus.req;
    assign pick = rr_pick(cand, last_q);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        valid_d = valid_q;
        hold_d  = hold_q;
        terr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.en && pick[IDX_W]) begin
                    state_d = BUSY;
                    idx_d   = pick[IDX_W-1:0];
                    last_d  = pick[IDX_W-1:0];
                    valid_d = 1'b1;
                    hold_d  = HOLD_W'(1);
                end
            end
            BUSY: begin
                if (release_c || timeout_c) begin
                    terr_d = timeout_c;
                    if (bus.en && pick[IDX_W]) begin
                        idx_d  = pick[IDX_W-1:0];
                        last_d = pick[IDX_W-1:0];
                        hold_d = HOLD_W'(1);
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        hold_d  = '0;
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                hold_d  = '0;
            end
        endcase
    end

    scm16_dec4_onehot u_dec (
        .sel_i    (idx_d),
        .dis_i    (!valid_d),
        .onehot_o (grant_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            valid_q <= 1'b0;
            hold_q  <= '0;
            terr_q  <= 1'b0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
            terr_q  <= terr_d;
            grant_q <= grant_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = valid_q;
    assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_scm16_rr_arbiter.sv
// Directed bench for scm16_rr_arbiter (MAX_HOLD=4).
// Each scenario task checks grant/idx/valid/timeout against hand-derived values.
module tb_scm16_rr_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    scm16_rr_arbiter_if u_if ();

    scm16_rr_arbiter #(
        .HOLD_W   (8),
        .MAX_HOLD (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        u_if.req   = '0;
        u_if.en    = 1'b1;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        u_if.req = 16'hFFFF;
        u_if.en  = 1'b1;
        step();
        checks++;
        if ({u_if.grant, u_if.grant_idx, u_if.grant_valid, u_if.timeout_err} !== 22'd0) begin
            errors++;
            $display("FAIL reset: grant=%h idx=%0d v=%b t=%b expected all zero",
                     u_if.grant, u_if.grant_idx, u_if.grant_valid, u_if.timeout_err);
        end
        u_if.req = '0;
        rst      = 1'b1;
        step();
    endtask

    task automatic test_single();
        do_reset();
        u_if.req = 16'h0008;
        step();
        checks++;
        if (u_if.grant !== 16'h0008 || u_if.grant_idx !== 4'd3 || u_if.grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: grant=%h idx=%0d v=%b expected 0008 3 1",
                     u_if.grant, u_if.grant_idx, u_if.grant_valid);
        end
        u_if.req = '0;
        step();
        checks++;
        if (u_if.grant !== 16'h0000 || u_if.grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_release: grant=%h v=%b expected 0000 0",
                     u_if.grant, u_if.grant_valid);
        end
    endtask

    task automatic test_rotation();
        logic [15:0] reqs [4];
        logic [15:0] exp  [4];
        reqs = '{16'h8001, 16'h8000, 16'h0001, 16'h8000};
        exp  = '{16'h0001, 16'h8000, 16'h0001, 16'h8000};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            u_if.req = reqs[i];
            step();
            checks++;
            if (u_if.grant !== exp[i] || u_if.grant_valid !== 1'b1) begin
                errors++;
                $display("FAIL rotation[%0d]: grant=%h v=%b expected %h 1",
                         i, u_if.grant, u_if.grant_valid, exp[i]);
            end
        end
        u_if.req = '0;
        step();
        checks++;
        if (u_if.grant_valid !== 1'b0 || u_if.grant !== 16'h0000) begin
            errors++;
            $display("FAIL rotation_idle: grant=%h v=%b expected 0000 0",
                     u_if.grant, u_if.grant_valid);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        u_if.req = 16'h4000;
        step();
        u_if.req = '0;
        step();
        u_if.req = 16'h4002;
        step();
        checks++;
        if (u_if.grant !== 16'h0002 || u_if.grant_idx !== 4'd1) begin
            errors++;
            $display("FAIL wrap: grant=%h idx=%0d expected 0002 1",
                     u_if.grant, u_if.grant_idx);
        end
        u_if.req = '0;
        step();
    endtask

    task automatic test_timeout();
        do_reset();
        u_if.req = 16'h0011;
        step();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (u_if.grant !== 16'h0001 || u_if.timeout_err !== 1'b0) begin
                errors++;
                $display("FAIL timeout_hold0[%0d]: grant=%h t=%b expected 0001 0",
                         i, u_if.grant, u_if.timeout_err);
            end
            step();
        end
        checks++;
        if (u_if.grant !== 16'h0010 || u_if.grant_idx !== 4'd4 || u_if.timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_revoke0: grant=%h idx=%0d t=%b expected 0010 4 1",
                     u_if.grant, u_if.grant_idx, u_if.timeout_err);
        end
        step();
        checks++;
        if (u_if.grant !== 16'h0010 || u_if.timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: grant=%h t=%b expected 0010 0",
                     u_if.grant, u_if.timeout_err);
        end
        step();
        step();
        step();
        checks++;
        if (u_if.grant !== 16'h0001 || u_if.timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_revoke4: grant=%h t=%b expected 0001 1",
                     u_if.grant, u_if.timeout_err);
        end
        u_if.req = '0;
        step();
    endtask

    task automatic test_en();
        do_reset();
        u_if.en  = 1'b0;
        u_if.req = 16'hFFFF;
        step();
        step();
        checks++;
        if (u_if.grant !== 16'h0000 || u_if.grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL en_block: grant=%h v=%b expected 0000 0",
                     u_if.grant, u_if.grant_valid);
        end
        u_if.en = 1'b1;
        step();
        checks++;
        if (u_if.grant !== 16'h0001 || u_if.grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL en_grant: grant=%h v=%b expected 0001 1",
                     u_if.grant, u_if.grant_valid);
        end
        u_if.en = 1'b0;
        step();
        checks++;
        if (u_if.grant !== 16'h0001) begin
            errors++;
            $display("FAIL en_keep: grant=%h expected 0001", u_if.grant);
        end
        u_if.req = 16'hFFFE;
        step();
        checks++;
        if (u_if.grant !== 16'h0000 || u_if.grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL en_no_handover: grant=%h v=%b expected 0000 0",
                     u_if.grant, u_if.grant_valid);
        end
        u_if.en = 1'b1;
        step();
        checks++;
        if (u_if.grant !== 16'h0002 || u_if.grant_idx !== 4'd1) begin
            errors++;
            $display("FAIL en_resume: grant=%h idx=%0d expected 0002 1",
                     u_if.grant, u_if.grant_idx);
        end
        u_if.req = '0;
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        u_if.req = 16'h0020;
        step();
        checks++;
        if (u_if.grant !== 16'h0020 || u_if.grant_idx !== 4'd5) begin
            errors++;
            $display("FAIL midrst_owner: grant=%h idx=%0d expected 0020 5",
                     u_if.grant, u_if.grant_idx);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (u_if.grant !== 16'h0000 || u_if.grant_valid !== 1'b0 || u_if.grant_idx !== 4'd0) begin
            errors++;
            $display("FAIL midrst_async: grant=%h v=%b idx=%0d expected 0000 0 0",
                     u_if.grant, u_if.grant_valid, u_if.grant_idx);
        end
        u_if.req = 16'h0021;
        #2;
        rst = 1'b1;
        step();
        checks++;
        if (u_if.grant !== 16'h0001 || u_if.grant_idx !== 4'd0) begin
            errors++;
            $display("FAIL midrst_restart: grant=%h idx=%0d expected 0001 0",
                     u_if.grant, u_if.grant_idx);
        end
        u_if.req = '0;
        step();
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b0;
        u_if.req = '0;
        u_if.en  = 1'b0;
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_timeout();
        test_en();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scm16_rr_arbiter.md
Name: scm16_rr_arbiter

Overview:
- Round-robin arbiter that shares one 16-way selected resource (bus, register-file write port, I/O slot) between 16 requesters.
- Output is a one-hot 16-bit grant driven through a 4-to-16 select decoder, plus the encoded grant index.
- A grant is held until the owner drops its request or a hold timeout fires.
- Sits between the SCM16 control unit and the decoder-selected resource; the same 4-bit index feeds other decoders.

Parameters:
- NUM_REQ, 16, number of requesters; fixed at 16 (4-bit index), not legal to change.
- HOLD_W, 8, width of the hold-timeout counter.
- MAX_HOLD, 200, maximum consecutive cycles one owner may hold the grant; must be at least 1 and at most 2^HOLD_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  16  request lines; bit i asserted means requester i wants the resource.
- en  input  1  global enable; when low, no new grant is issued (analogous to decoder Disable).
- grant  output  16  one-hot grant; all zero when no owner.
- grant_idx  output  4  encoded owner index; valid only when grant_valid=1.
- grant_valid  output  1  an owner currently holds the resource.
- timeout_err  output  1  one-cycle pulse when an owner is revoked by timeout.

Behaviour:
- Reset (rst=0, asynchronous):
  - grant=0, grant_idx=0, grant_valid=0, timeout_err=0.
  - State=IDLE, hold counter=0, last_idx=15, so requester 0 has highest priority after reset.
- State IDLE:
  - If en=1 and req!=0, select the first set bit scanning last_idx+1, last_idx+2, … with wrap 15→0.
  - On the next clock edge: state→BUSY, grant_idx=winner, grant_valid=1, grant=decode(winner), hold counter=1, last_idx=winner.
  - Latency from request to grant is exactly 1 cycle.
- State BUSY, checked in priority order:
  - Release: if req[grant_idx]=0, release at the next edge.
  - Timeout: else if hold counter==MAX_HOLD, revoke at the next edge and pulse timeout_err=1 for exactly one cycle.
  - Otherwise: increment the hold counter.
  - en going low does not revoke a grant already issued.
- Handover on release or revoke:
  - If en=1 and another requester is pending, arbitrate in the same cycle and grant the new winner at that edge (zero-gap handover; state stays BUSY, counter=1).
  - The releasing or revoked index is excluded from that arbitration.
  - Otherwise go to IDLE with grant=0 and grant_valid=0.
- Re-request after timeout: a timed-out requester that keeps req asserted re-enters the normal round-robin order; it cannot win again until every other pending requester has been served.
- Output invariants:
  - grant is always one-hot or zero.
  - grant==0 exactly when grant_valid==0.
  - All outputs are registered; no combinational path from req to grant.
- Simultaneous requests: resolved only by rotating priority; there is no fixed priority beyond the reset point.
- Reset mid-grant: outputs drop immediately (asynchronously); priority restarts at requester 0.

Decomposition:
- Package scm16_arb_pkg: NUM_REQ=16, IDX_W=4, and the state enum {IDLE, BUSY}.
- Sub-module scm16_dec4_onehot: a purely combinational 4-to-16 decoder with an active-high disable. It is instantiated once to produce grant from the next index, gated by the next grant_valid, and is reusable by other decoder consumers.
- The rotating priority encoder stays inline as a function.

Test Plan:
- Single request: after reset, req=0x0008 → one cycle later grant=0x0008, grant_idx=3, grant_valid=1; drop req → next cycle grant=0.
- Rotation: req=0x8001 held, each owner drops and re-raises its request after 1 cycle → grants go 0, then 15, then 0, with zero-gap handover.
- Wrap-around: last_idx=14, req=0x4002 → winner is 1 (scan order 15, 0, 1), not 14.
- Timeout: MAX_HOLD=4, req=0x0011 held → owner 0 for 4 cycles, timeout_err pulses once, owner 4 granted at the same edge.
- en gating: en=0 with req=0xFFFF → grant stays 0. Set en=1 → grant=0x0001. Then en=0 while owner 0 holds → grant is kept until release.
- Reset mid-grant: owner 5 active, rst=0 asserted asynchronously between edges → grant=0 immediately. After rst=1 with req=0x0021 → owner 0 wins.
